// File: rtl/load_register_pkg.sv
// Shared CPU-wide constants used to size and reset architectural registers.
package load_register_pkg;

  // Architectural register width.
  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] xword_t;

  // Reset contents of every architectural register.
  localparam xword_t REG_ZERO = 32'h0000_0000;

endpackage

// File: rtl/load_register_if.sv
// Write/read bundle for one register: shared write data, per-register load, stored value.
interface load_register_if
  import load_register_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
);

  logic [WIDTH-1:0] in;
  logic             load;
  logic [WIDTH-1:0] out;

  // Driven by the register file write port; observes the stored value.
  modport master (
    output in,
    output load,
    input  out
  );

  // The register itself.
  modport slave (
    input  in,
    input  load,
    output out
  );

endinterface

// File: rtl/load_register.sv
// Single architectural register: synchronous load, asynchronous active-low clear.
// out comes straight from the flops, so there is no combinational path from in.
module load_register
  import load_register_pkg::*;
#(
  parameter int unsigned      WIDTH       = XLEN,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input logic                  clk,
  input logic                  reset,  // active low
  load_register_if.slave       bus
);

  // Capture in when load is high; reset wins over load and clk at all times.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.out <= RESET_VALUE;
    end else if (bus.load) begin
      bus.out <= bus.in;
    end
  end

endmodule

// File: tb/tb_load_register.sv
// Directed plus randomized bench for load_register, checked against a behavioural model.
module tb_load_register;
  import load_register_pkg::*;

  localparam int unsigned W = XLEN;
  localparam logic [W-1:0] RST_VAL = REG_ZERO;

  logic clk = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;

  // Expected register contents, derived from the behavioural rules.
  logic [W-1:0] model;

  load_register_if #(.WIDTH(W)) bus ();
  load_register_if #(.WIDTH(W)) zbus ();

  load_register #(
    .WIDTH       (W),
    .RESET_VALUE (RST_VAL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Register-zero configuration: reset held low, load high, in zero.
  load_register #(
    .WIDTH       (W),
    .RESET_VALUE (RST_VAL)
  ) zdut (
    .clk   (clk),
    .reset (1'b0),
    .bus   (zbus.slave)
  );

  assign zbus.in   = '0;
  assign zbus.load = 1'b1;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: apply inputs, let one rising edge pass, check at the next fall.
  task automatic step(input string tag, input logic ld, input logic [W-1:0] data);
    bus.load = ld;
    bus.in   = data;
    @(posedge clk);
    if (!reset) model = RST_VAL;
    else if (ld) model = data;
    @(negedge clk);
    check(tag, bus.out, model);
    check("zero_reg", zbus.out, RST_VAL);
  endtask

  // Called at a falling edge: pull reset low mid-cycle with a pending load,
  // hold it across one rising edge, release on the next falling edge.
  task automatic reset_pulse(input string tag, input logic [W-1:0] junk);
    bus.load = 1'b1;
    bus.in   = junk;
    #2;
    reset = 1'b0;
    model = RST_VAL;
    #1;
    check({tag, "_async"}, bus.out, model);
    @(negedge clk);
    check({tag, "_held"}, bus.out, model);
    reset    = 1'b1;
    bus.load = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    bus.load = 1'b1;
    bus.in   = 32'hDEAD_BEEF;
    model    = 'x;

    // Get a non-zero value in first so the asynchronous clear is observable.
    step("preload", 1'b1, 32'hDEAD_BEEF);

    // Assert reset between edges; out must clear before any rising edge.
    #2;
    reset = 1'b0;
    model = RST_VAL;
    #1;
    check("reset_async", bus.out, model);
    @(negedge clk);
    for (int i = 0; i < 3; i++) step("reset_hold", 1'b1, 32'hDEAD_BEEF);

    // Release on a falling edge with load low: value must stay at reset.
    reset = 1'b1;
    step("release_hold", 1'b0, 32'hDEAD_BEEF);

    step("load", 1'b1, 32'h1234_5678);
    for (int i = 0; i < 4; i++) step("hold", 1'b0, 32'hFFFF_FFFF);

    step("b2b_1", 1'b1, 32'd1);
    step("b2b_2", 1'b1, 32'd2);
    step("b2b_3", 1'b1, 32'd3);

    step("pre_mid", 1'b1, 32'hA5A5_A5A5);
    reset_pulse("mid_reset", 32'h0BAD_F00D);
    step("after_mid0", 1'b0, 32'h5555_5555);
    step("after_mid1", 1'b0, 32'h5555_5555);

    step("bound_ones", 1'b1, 32'hFFFF_FFFF);
    step("bound_msb",  1'b1, 32'h8000_0000);
    step("bound_lsb",  1'b1, 32'h0000_0001);

    // Random loads and holds with occasional mid-cycle reset pulses.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        reset_pulse("rand_reset", $urandom());
      end else begin
        step("rand", 1'($urandom_range(0, 1)), $urandom());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
